// File: rtl/spi_frame_rx_if.sv
// Downstream frame interface of the SPI frame receiver.
//
// Handshake: the receiver (master) raises rx_valid_out with a frame on
// rx_header_out/rx_message_out and keeps all three stable until the consumer
// (slave) samples rx_ready_in high on a rising clock edge; valid && ready on
// an edge is exactly one transfer. rx_ready_in may be high while rx_valid_out
// is low, which has no effect. rx_error_out / rx_overrun_out are single-cycle
// status pulses that are not part of the handshake.
//
// Signals:
//   rx_header_out   header of held frame
//   rx_message_out  message of held frame
//   rx_valid_out    held frame available
//   rx_ready_in     consumer accepts
//   rx_error_out    pulse: frame with wrong bit count discarded
//   rx_overrun_out  pulse: good frame dropped, holding register full
interface spi_frame_rx_if #(
  parameter int MESSAGE_SIZE = 512,
  parameter int HEADER_SIZE  = 32
);
  logic [HEADER_SIZE-1:0]  rx_header_out;
  logic [MESSAGE_SIZE-1:0] rx_message_out;
  logic                    rx_valid_out;
  logic                    rx_ready_in;
  logic                    rx_error_out;
  logic                    rx_overrun_out;

  modport master (
    output rx_header_out, rx_message_out, rx_valid_out,
    output rx_error_out, rx_overrun_out,
    input  rx_ready_in
  );

  modport slave (
    input  rx_header_out, rx_message_out, rx_valid_out,
    input  rx_error_out, rx_overrun_out,
    output rx_ready_in
  );
endinterface

// File: rtl/spi_frame_rx.sv
// SPI frame receiver. Oversamples the peer's asynchronous SCLK / active-low
// SEL / DATA wires in the clk_in domain, deserializes one {header,message}
// frame per SEL-low window (MSB first) and presents it through a single
// holding register on the valid/ready interface.
//
// Ports:
//   clk_in      system clock
//   rst_in      asynchronous active-high reset
//   rx_clk_in   peer SCLK (async), data taken on its rising edge
//   rx_sel_in   peer select (async), active low
//   rx_data_in  peer serial data (async)
//   rx_if       downstream frame interface (master side)
//   state_dbg   current FSM state (IDLE=0, SHIFT=1, WAIT_HIGH=2)
module spi_frame_rx #(
  parameter int MESSAGE_SIZE = 512,
  parameter int HEADER_SIZE  = 32,
  parameter int SYNC_STAGES  = 2
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rx_clk_in,
  input  logic           rx_sel_in,
  input  logic           rx_data_in,
  spi_frame_rx_if.master rx_if,
  output logic [1:0]     state_dbg
);

  localparam int FRAME_SIZE = HEADER_SIZE + MESSAGE_SIZE;
  localparam int CNT_W      = $clog2(FRAME_SIZE + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_SIZE);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_SIZE + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT     = 2'd1,
    WAIT_HIGH = 2'd2
  } state_t;

  state_t state;
  assign state_dbg = state;

  // Synchronizer chains, edge-detect flops and registered edge strobes.
  logic [SYNC_STAGES-1:0] sclk_sync, sel_sync, data_sync;
  logic                   sclk_d, sel_d, data_d;
  logic                   sclk_rise, sel_fall, sel_rise;
  logic                   sclk_s, sel_s, data_s;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign sel_s  = sel_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  // The sel chain resets to 1 regardless of the pad, so right after reset
  // sel_s can claim "high" while the real wire is low. WAIT_HIGH only trusts
  // sel_s once the reset values have been flushed through the whole chain
  // and the edge-detect flop.
  logic [SYNC_STAGES:0] flush;
  logic                 settled;
  assign settled = flush[SYNC_STAGES];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sclk_sync <= '0;
      sel_sync  <= '1;
      data_sync <= '0;
      sclk_d    <= 1'b0;
      sel_d     <= 1'b1;
      data_d    <= 1'b0;
      sclk_rise <= 1'b0;
      sel_fall  <= 1'b0;
      sel_rise  <= 1'b0;
      flush     <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], rx_clk_in};
      sel_sync  <= {sel_sync[SYNC_STAGES-2:0], rx_sel_in};
      data_sync <= {data_sync[SYNC_STAGES-2:0], rx_data_in};
      sclk_d    <= sclk_s;
      sel_d     <= sel_s;
      // data_d lines up with the registered sclk_rise strobe.
      data_d    <= data_s;
      sclk_rise <= sclk_s & ~sclk_d;
      sel_fall  <= ~sel_s & sel_d;
      sel_rise  <= sel_s & ~sel_d;
      flush     <= {flush[SYNC_STAGES-1:0], 1'b1};
    end
  end

  logic [CNT_W-1:0]      cnt;
  logic [FRAME_SIZE-1:0] shreg;
  logic                  hold_free;

  // Holding register can take a new frame if empty or being emptied now.
  assign hold_free = ~rx_if.rx_valid_out | rx_if.rx_ready_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state                <= WAIT_HIGH;
      cnt                  <= '0;
      shreg                <= '0;
      rx_if.rx_header_out  <= '0;
      rx_if.rx_message_out <= '0;
      rx_if.rx_valid_out   <= 1'b0;
      rx_if.rx_error_out   <= 1'b0;
      rx_if.rx_overrun_out <= 1'b0;
    end else begin
      rx_if.rx_error_out   <= 1'b0;
      rx_if.rx_overrun_out <= 1'b0;
      if (rx_if.rx_valid_out && rx_if.rx_ready_in) begin
        rx_if.rx_valid_out <= 1'b0;
      end

      case (state)
        WAIT_HIGH: begin
          if (settled && sel_s) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (sel_fall) begin
            state <= SHIFT;
            cnt   <= '0;
            shreg <= '0;
          end
        end
        SHIFT: begin
          if (sel_rise) begin
            state <= IDLE;
            if (cnt != CNT_FULL) begin
              rx_if.rx_error_out <= 1'b1;
            end else if (hold_free) begin
              rx_if.rx_header_out  <= shreg[FRAME_SIZE-1:MESSAGE_SIZE];
              rx_if.rx_message_out <= shreg[MESSAGE_SIZE-1:0];
              rx_if.rx_valid_out   <= 1'b1;
            end else begin
              rx_if.rx_overrun_out <= 1'b1;
            end
          end else if (sclk_rise) begin
            shreg <= {shreg[FRAME_SIZE-2:0], data_d};
            if (cnt != CNT_SAT) begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= WAIT_HIGH;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx with 8-bit header, 8-bit message and an
// SCLK of clk/8. Each scenario task drives a few frames and checks results.
module tb_spi_frame_rx;
  localparam int MS = 8;
  localparam int HS = 8;
  localparam int SS = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_sclk = 1'b0;
  logic rx_sel = 1'b1;
  logic rx_data = 1'b0;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  spi_frame_rx_if #(.MESSAGE_SIZE(MS), .HEADER_SIZE(HS)) rx_if ();

  spi_frame_rx #(.MESSAGE_SIZE(MS), .HEADER_SIZE(HS), .SYNC_STAGES(SS)) dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .rx_clk_in (rx_sclk),
    .rx_sel_in (rx_sel),
    .rx_data_in(rx_data),
    .rx_if     (rx_if),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- monitor / scoreboard ----------------
  int valid_cycles = 0;
  int err_pulses = 0;
  int ovr_pulses = 0;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] exp_w, got_w;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_if.rx_valid_out) valid_cycles++;
      if (rx_if.rx_error_out) err_pulses++;
      if (rx_if.rx_overrun_out) ovr_pulses++;
      if (rx_if.rx_valid_out && rx_if.rx_ready_in)
        got_q.push_back({rx_if.rx_header_out, rx_if.rx_message_out});
    end
  end

  initial begin
    #500us;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic open_frame();
    rx_sel = 1'b0;
    tick(4);
  endtask

  task automatic shift_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      rx_data = bits[i];
      rx_sclk = 1'b0;
      tick(4);
      rx_sclk = 1'b1;
      tick(4);
    end
  endtask

  task automatic close_frame();
    rx_sclk = 1'b0;
    tick(4);
    rx_sel = 1'b1;
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    open_frame();
    shift_bits(bits, n);
    close_frame();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rx_if.rx_ready_in = 1'b0;
    rst = 1'b1;
    tick(3);
    checks++; if (rx_if.rx_valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", rx_if.rx_valid_out); end
    checks++; if (rx_if.rx_error_out !== 1'b0) begin errors++; $display("FAIL rst_error got=%b exp=0", rx_if.rx_error_out); end
    checks++; if (rx_if.rx_overrun_out !== 1'b0) begin errors++; $display("FAIL rst_overrun got=%b exp=0", rx_if.rx_overrun_out); end
    checks++; if (rx_if.rx_header_out !== 8'h00) begin errors++; $display("FAIL rst_header got=%h exp=00", rx_if.rx_header_out); end
    checks++; if (rx_if.rx_message_out !== 8'h00) begin errors++; $display("FAIL rst_message got=%h exp=00", rx_if.rx_message_out); end
    checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL rst_state got=%0d exp=2", state_dbg); end
    rst = 1'b0;
    tick(10);
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL rst_idle got=%0d exp=0", state_dbg); end
  endtask

  task automatic test_basic();
    int v0, e0, o0, lat;
    bit found;
    rx_if.rx_ready_in = 1'b1;
    v0 = valid_cycles; e0 = err_pulses; o0 = ovr_pulses;
    exp_q.push_back(16'hA53C);
    send_bits(32'h0000A53C, 16);
    found = 1'b0; lat = 0;
    for (int k = 1; k <= 10 && !found; k++) begin
      tick(1);
      if (rx_if.rx_valid_out === 1'b1) begin
        found = 1'b1;
        lat = k;
        checks++; if (rx_if.rx_header_out !== 8'hA5) begin errors++; $display("FAIL basic_header got=%h exp=a5", rx_if.rx_header_out); end
        checks++; if (rx_if.rx_message_out !== 8'h3C) begin errors++; $display("FAIL basic_message got=%h exp=3c", rx_if.rx_message_out); end
      end
    end
    checks++; if (!found || lat != 4) begin errors++; $display("FAIL basic_latency got=%0d exp=4 (found=%0d)", lat, found); end
    tick(10);
    checks++; if (valid_cycles - v0 != 1) begin errors++; $display("FAIL basic_valid_cycles got=%0d exp=1", valid_cycles - v0); end
    checks++; if (err_pulses - e0 != 0) begin errors++; $display("FAIL basic_error got=%0d exp=0", err_pulses - e0); end
    checks++; if (ovr_pulses - o0 != 0) begin errors++; $display("FAIL basic_overrun got=%0d exp=0", ovr_pulses - o0); end
    while (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL basic_frame got=none exp=%h", exp_w); end
      else begin got_w = got_q.pop_front(); if (got_w !== exp_w) begin errors++; $display("FAIL basic_frame got=%h exp=%h", got_w, exp_w); end end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL basic_extra got=%0d exp=0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_overrun();
    int o0;
    rx_if.rx_ready_in = 1'b0;
    o0 = ovr_pulses;
    exp_q.push_back(16'h1234);
    send_bits(32'h00001234, 16);
    tick(8);
    checks++; if (rx_if.rx_valid_out !== 1'b1) begin errors++; $display("FAIL ovr_first_valid got=%b exp=1", rx_if.rx_valid_out); end
    send_bits(32'h0000BEEF, 16);
    tick(8);
    checks++; if (ovr_pulses - o0 != 1) begin errors++; $display("FAIL ovr_pulses got=%0d exp=1", ovr_pulses - o0); end
    checks++; if (rx_if.rx_valid_out !== 1'b1) begin errors++; $display("FAIL ovr_held_valid got=%b exp=1", rx_if.rx_valid_out); end
    checks++; if ({rx_if.rx_header_out, rx_if.rx_message_out} !== 16'h1234) begin
      errors++; $display("FAIL ovr_held_frame got=%h exp=1234", {rx_if.rx_header_out, rx_if.rx_message_out}); end
    rx_if.rx_ready_in = 1'b1;
    tick(2);
    checks++; if (rx_if.rx_valid_out !== 1'b0) begin errors++; $display("FAIL ovr_valid_drop got=%b exp=0", rx_if.rx_valid_out); end
    while (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL ovr_frame got=none exp=%h", exp_w); end
      else begin got_w = got_q.pop_front(); if (got_w !== exp_w) begin errors++; $display("FAIL ovr_frame got=%h exp=%h", got_w, exp_w); end end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL ovr_extra got=%0d exp=0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_bad_length();
    int v0, e0;
    rx_if.rx_ready_in = 1'b1;
    v0 = valid_cycles; e0 = err_pulses;
    send_bits(32'h00005A5A, 15);
    tick(10);
    send_bits(32'h0001ABCD, 17);
    tick(10);
    checks++; if (err_pulses - e0 != 2) begin errors++; $display("FAIL len_errors got=%0d exp=2", err_pulses - e0); end
    checks++; if (valid_cycles - v0 != 0) begin errors++; $display("FAIL len_valid got=%0d exp=0", valid_cycles - v0); end
    exp_q.push_back(16'h0F0F);
    send_bits(32'h00000F0F, 16);
    tick(10);
    checks++; if (err_pulses - e0 != 2) begin errors++; $display("FAIL len_good_error got=%0d exp=2", err_pulses - e0); end
    while (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL len_frame got=none exp=%h", exp_w); end
      else begin got_w = got_q.pop_front(); if (got_w !== exp_w) begin errors++; $display("FAIL len_frame got=%h exp=%h", got_w, exp_w); end end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL len_extra got=%0d exp=0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_mid_reset();
    int v0, e0;
    rx_if.rx_ready_in = 1'b1;
    open_frame();
    shift_bits(32'h00000187, 9);
    rst = 1'b1;
    tick(2);
    checks++; if (state_dbg !== 2'd2) begin errors++; $display("FAIL mrst_state got=%0d exp=2", state_dbg); end
    rst = 1'b0;
    v0 = valid_cycles; e0 = err_pulses;
    shift_bits(32'h00000043, 7);
    close_frame();
    tick(12);
    checks++; if (err_pulses - e0 != 0) begin errors++; $display("FAIL mrst_error got=%0d exp=0", err_pulses - e0); end
    checks++; if (valid_cycles - v0 != 0) begin errors++; $display("FAIL mrst_valid got=%0d exp=0", valid_cycles - v0); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL mrst_idle got=%0d exp=0", state_dbg); end
    exp_q.push_back(16'hC3C3);
    send_bits(32'h0000C3C3, 16);
    tick(12);
    while (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL mrst_frame got=none exp=%h", exp_w); end
      else begin got_w = got_q.pop_front(); if (got_w !== exp_w) begin errors++; $display("FAIL mrst_frame got=%h exp=%h", got_w, exp_w); end end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mrst_extra got=%0d exp=0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_back_to_back();
    int o0;
    rx_if.rx_ready_in = 1'b0;
    o0 = ovr_pulses;
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h2222);
    send_bits(32'h00001111, 16);
    tick(8);
    send_bits(32'h00002222, 16);
    // Sel-rise strobe is visible from the 3rd edge after the pad edge.
    tick(3);
    rx_if.rx_ready_in = 1'b1;
    tick(1);
    rx_if.rx_ready_in = 1'b0;
    checks++; if (rx_if.rx_valid_out !== 1'b1) begin errors++; $display("FAIL b2b_valid got=%b exp=1", rx_if.rx_valid_out); end
    checks++; if ({rx_if.rx_header_out, rx_if.rx_message_out} !== 16'h2222) begin
      errors++; $display("FAIL b2b_held got=%h exp=2222", {rx_if.rx_header_out, rx_if.rx_message_out}); end
    tick(4);
    checks++; if (ovr_pulses - o0 != 0) begin errors++; $display("FAIL b2b_overrun got=%0d exp=0", ovr_pulses - o0); end
    rx_if.rx_ready_in = 1'b1;
    tick(3);
    checks++; if (rx_if.rx_valid_out !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", rx_if.rx_valid_out); end
    while (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL b2b_frame got=none exp=%h", exp_w); end
      else begin got_w = got_q.pop_front(); if (got_w !== exp_w) begin errors++; $display("FAIL b2b_frame got=%h exp=%h", got_w, exp_w); end end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL b2b_extra got=%0d exp=0", got_q.size()); got_q.delete(); end
  endtask

  task automatic test_idle_sclk();
    int e0, o0, v0;
    rx_if.rx_ready_in = 1'b1;
    e0 = err_pulses; o0 = ovr_pulses; v0 = valid_cycles;
    rx_sel = 1'b1;
    rx_data = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rx_sclk = 1'b1;
      tick(4);
      rx_sclk = 1'b0;
      tick(4);
    end
    tick(8);
    checks++; if (valid_cycles - v0 != 0) begin errors++; $display("FAIL idle_valid got=%0d exp=0", valid_cycles - v0); end
    exp_q.push_back(16'h8001);
    send_bits(32'h00008001, 16);
    tick(12);
    checks++; if (err_pulses - e0 != 0) begin errors++; $display("FAIL idle_error got=%0d exp=0", err_pulses - e0); end
    checks++; if (ovr_pulses - o0 != 0) begin errors++; $display("FAIL idle_overrun got=%0d exp=0", ovr_pulses - o0); end
    while (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL idle_frame got=none exp=%h", exp_w); end
      else begin got_w = got_q.pop_front(); if (got_w !== exp_w) begin errors++; $display("FAIL idle_frame got=%h exp=%h", got_w, exp_w); end end
    end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL idle_extra got=%0d exp=0", got_q.size()); got_q.delete(); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rx_if.rx_ready_in = 1'b0;
    test_reset();
    test_basic();
    test_overrun();
    test_bad_length();
    test_mid_reset();
    test_back_to_back();
    test_idle_sclk();
    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
